// File: rtl/data_mem_port_if.sv
// ----------------------------------------------------------------------------
// data_mem_port_if
//   SRAM-like request/response bus between the data-memory port and the data
//   cache / AXI bridge. The port drives the request side (master); the cache or
//   bridge answers with addr_ok / data_ok / rdata (slave).
//
//   Signals
//     req      master->slave  request valid, held until addr_ok
//     wr       master->slave  1 = write
//     wstrb    master->slave  byte write enables (DATA_W/8)
//     addr     master->slave  byte address (ADDR_W)
//     wdata    master->slave  store data (DATA_W)
//     addr_ok  slave->master  request accepted this cycle (meaningful only with req)
//     data_ok  slave->master  read data / write ack this cycle
//     rdata    slave->master  read data, valid with data_ok on reads
// ----------------------------------------------------------------------------
interface data_mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  wr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  addr_ok;
  logic                  data_ok;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_mem_port.sv
// ----------------------------------------------------------------------------
// data_mem_port
//   Responder side of the core's data-memory interface. A single-cycle core
//   request (mem_en / mem_wstrb) is latched and run on the SRAM-like bus; the
//   pipeline is held with mem_stall until the bus completes, and load data is
//   presented in the one-cycle DONE state.
//
//   FSM: IDLE -> REQ -> (WAIT) -> DONE -> IDLE. Every output is registered
//   except mem_stall.
//
//   Ports
//     clk        rising-edge clock
//     resetn     synchronous reset, active low
//     mem_en     core request valid (held while mem_stall=1)
//     mem_wstrb  byte write enables, all-zero = read
//     mem_addr   byte address
//     mem_wdata  store data
//     mem_stall  pipeline hold
//     mem_rdata  load data, valid in DONE
//     mem_err    bus timeout pulse during DONE (0 when timeout is disabled)
//     bus        data_mem_port_if.master, SRAM-like bus
//
//   Build option: define DMEM_TIMEOUT_EN to abort a bus access that has been
//   in REQ/WAIT for TIMEOUT_CYCLES cycles (mem_err=1, mem_rdata=0).
// ----------------------------------------------------------------------------
module data_mem_port #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_en,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err,
  data_mem_port_if.master     bus
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("data_mem_port: TIMEOUT_CYCLES must be in 1..1023");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic                req_reg, req_next;
  logic                wr_reg, wr_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;

`ifdef DMEM_TIMEOUT_EN
  localparam logic [9:0] TIMEOUT_LIMIT = 10'(TIMEOUT_CYCLES);
  logic [9:0] count_reg, count_next;
  logic       err_reg, err_next;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      req_reg   <= 1'b0;
      wr_reg    <= 1'b0;
      wstrb_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
`ifdef DMEM_TIMEOUT_EN
      count_reg <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      wr_reg    <= wr_next;
      wstrb_reg <= wstrb_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
`ifdef DMEM_TIMEOUT_EN
      count_reg <= count_next;
      err_reg   <= err_next;
`endif
    end
  end

  // Next-state and stall logic
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    wr_next    = wr_reg;
    wstrb_next = wstrb_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    mem_stall  = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    count_next = count_reg;
    err_next   = 1'b0;
`endif

    case (state_reg)
      S_IDLE: begin
        mem_stall = mem_en;
        if (mem_en) begin
          addr_next  = mem_addr;
          wdata_next = mem_wdata;
          wstrb_next = mem_wstrb;
          wr_next    = |mem_wstrb;
          req_next   = 1'b1;
          state_next = S_REQ;
`ifdef DMEM_TIMEOUT_EN
          count_next = '0;
`endif
        end
      end
      S_REQ: begin
        mem_stall = 1'b1;
        // data_ok without addr_ok is spurious and ignored here
        if (bus.addr_ok) begin
          req_next = 1'b0;
          if (bus.data_ok) begin
            state_next = S_DONE;
            if (!wr_reg) rdata_next = bus.rdata;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        if (bus.data_ok) begin
          state_next = S_DONE;
          if (!wr_reg) rdata_next = bus.rdata;
        end
      end
      S_DONE: begin
        // mem_en here still belongs to the op that just finished
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

`ifdef DMEM_TIMEOUT_EN
    // A real bus completion in the limit cycle wins over the timeout.
    if (state_reg == S_REQ || state_reg == S_WAIT) begin
      count_next = count_reg + 10'd1;
      if (state_next != S_DONE && count_next == TIMEOUT_LIMIT) begin
        state_next = S_DONE;
        req_next   = 1'b0;
        rdata_next = '0;
        err_next   = 1'b1;
      end
    end
`endif
  end

  assign bus.req   = req_reg;
  assign bus.wr    = wr_reg;
  assign bus.wstrb = wstrb_reg;
  assign bus.addr  = addr_reg;
  assign bus.wdata = wdata_reg;
  assign mem_rdata = rdata_reg;

`ifdef DMEM_TIMEOUT_EN
  assign mem_err = err_reg;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_port.sv
// ----------------------------------------------------------------------------
// tb_data_mem_port
//   Self-checking bench for data_mem_port: directed vector table, random
//   transactions against a transaction-level model, and hand-written sequences
//   for reset-in-WAIT and (with DMEM_TIMEOUT_EN) the bus timeout.
// ----------------------------------------------------------------------------
module tb_data_mem_port;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          mem_en = 1'b0;
  logic [SW-1:0] mem_wstrb = '0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_stall;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;

  int errors = 0;
  int checks = 0;

  data_mem_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  data_mem_port #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_en    (mem_en),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;      // data the bus returns
    int            d1;         // REQ cycles before addr_ok
    bit            same;       // data_ok together with addr_ok
    int            d2;         // WAIT cycles before data_ok
    bit            spur;       // spurious data_ok in REQ before addr_ok
    int            exp_stall;
    logic          exp_wr;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [SW-1:0] ws, logic [AW-1:0] a, logic [DW-1:0] wd,
                              logic [DW-1:0] rd, int d1, bit same, int d2, bit spur,
                              int es, logic ew, logic [DW-1:0] er);
    vec_t v;
    v.wstrb = ws; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.d1 = d1; v.same = same; v.d2 = d2; v.spur = spur;
    v.exp_stall = es; v.exp_wr = ew; v.exp_rdata = er;
    return v;
  endfunction

  // Transaction-level model: one IDLE cycle, d1+1 REQ cycles, and d2+1 WAIT
  // cycles unless data_ok arrives with addr_ok. Writes keep the old load data.
  function automatic vec_t model(vec_t v, logic [DW-1:0] last);
    v.exp_wr    = (v.wstrb != '0);
    v.exp_stall = 2 + v.d1 + (v.same ? 0 : v.d2 + 1);
    v.exp_rdata = v.exp_wr ? last : v.rdata;
    return v;
  endfunction

  // Runs one access, acting as bus slave, and checks the core-side results.
  task automatic run_txn(input vec_t v, input int idx);
    int stall_cnt = 0;
    int rc = 0;
    int wc = 0;
    bit acc = 0;
    bit acc_n;
    bit done = 0;
    mem_en = 1'b1; mem_wstrb = v.wstrb; mem_addr = v.addr; mem_wdata = v.wdata;
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0;
    #1;
    chk("stall_idle_en", mem_stall, 1'b1);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (!mem_stall) begin
        done = 1;
      end else begin
        stall_cnt++;
        bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = $urandom;
        acc_n = acc;
        if (!acc && bus_if.req) begin
          chk("req_addr",  bus_if.addr,  v.addr);
          chk("req_wdata", bus_if.wdata, v.wdata);
          chk("req_wstrb", 32'(bus_if.wstrb), 32'(v.wstrb));
          chk("req_wr",    bus_if.wr,    v.exp_wr);
          if (rc == v.d1) begin
            bus_if.addr_ok = 1'b1;
            acc_n = 1;
            if (v.same) begin bus_if.data_ok = 1'b1; bus_if.rdata = v.rdata; end
          end else if (v.spur) begin
            bus_if.data_ok = 1'b1;
          end
          rc++;
        end else if (acc) begin
          if (wc == v.d2) begin bus_if.data_ok = 1'b1; bus_if.rdata = v.rdata; end
          wc++;
        end
        step();
        acc = acc_n;
        // The core is free to change these; the port must use its latched copy.
        mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = SW'($urandom);
        #1;
      end
    end
    chk("txn_completes", 32'(done), 32'd1);
    chk("stall_cycles", stall_cnt, v.exp_stall);
    chk("done_rdata", mem_rdata, v.exp_rdata);
    chk("done_err", mem_err, 1'b0);
    chk("done_req", bus_if.req, 1'b0);
    // Spurious data_ok in DONE and in the following IDLE; mem_en still high in DONE.
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = $urandom;
    step();
    mem_en = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = $urandom;
    #1;
    chk("idle_stall", mem_stall, 1'b0);
    chk("idle_req", bus_if.req, 1'b0);
    step();
    bus_if.data_ok = 1'b0;
    chk("idle_rdata_hold", mem_rdata, v.exp_rdata);
    chk("idle_req2", bus_if.req, 1'b0);
    $display("txn %0d: wstrb=%b addr=%h d1=%0d same=%0d d2=%0d stall=%0d rdata=%h",
             idx, v.wstrb, v.addr, v.d1, v.same, v.d2, stall_cnt, mem_rdata);
  endtask

  vec_t tbl[7];
  vec_t rv;
  logic [DW-1:0] last;

  initial begin
    // Directed vectors with hand-derived expectations
    tbl[0] = mk(4'b0000, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 0, 0, 0, 3, 1'b0, 32'h1234_5678);
    tbl[1] = mk(4'b0011, 32'h0000_0100, 32'hAABB_CCDD, 32'hDEAD_BEEF, 0, 0, 0, 0, 3, 1'b1, 32'h1234_5678);
    tbl[2] = mk(4'b0000, 32'h0000_0204, 32'h0, 32'h0BAD_F00D, 5, 0, 0, 0, 8, 1'b0, 32'h0BAD_F00D);
    tbl[3] = mk(4'b0000, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 0, 2, 1'b0, 32'hCAFE_F00D);
    tbl[4] = mk(4'b0000, 32'h0000_0408, 32'h0, 32'h5555_AAAA, 2, 0, 0, 1, 5, 1'b0, 32'h5555_AAAA);
    tbl[5] = mk(4'b1111, 32'h0000_050C, 32'h0102_0304, 32'h7777_7777, 1, 0, 2, 0, 6, 1'b1, 32'h5555_AAAA);
    tbl[6] = mk(4'b0100, 32'h0000_0602, 32'h00EE_0000, 32'h6666_6666, 3, 1, 0, 0, 5, 1'b1, 32'h5555_AAAA);

    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = '0;

    // Reset state
    resetn = 1'b0;
    step(); step();
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_req",   bus_if.req, 1'b0);
    chk("rst_wr",    bus_if.wr, 1'b0);
    chk("rst_wstrb", 32'(bus_if.wstrb), 32'd0);
    chk("rst_addr",  bus_if.addr, 32'd0);
    chk("rst_wdata", bus_if.wdata, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_err",   mem_err, 1'b0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_txn(tbl[i], i);

    // Random accesses against the model
    last = tbl[6].exp_rdata;
    for (int i = 0; i < 40; i++) begin
      rv.wstrb = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
      rv.addr  = $urandom; rv.wdata = $urandom; rv.rdata = $urandom;
      rv.d1 = $urandom_range(0, 3); rv.same = 1'($urandom_range(0, 1));
      rv.d2 = $urandom_range(0, 2); rv.spur = 1'($urandom_range(0, 1));
      rv = model(rv, last);
      run_txn(rv, 100 + i);
      last = rv.exp_rdata;
    end

    // Reset while in WAIT abandons the access
    mem_en = 1'b1; mem_wstrb = '0; mem_addr = 32'h0000_0800;
    step();                       // REQ
    bus_if.addr_ok = 1'b1;
    step();                       // WAIT
    bus_if.addr_ok = 1'b0;
    chk("wait_stall", mem_stall, 1'b1);
    chk("wait_req", bus_if.req, 1'b0);
    resetn = 1'b0;
    step();
    resetn = 1'b1; mem_en = 1'b0;
    #1;
    chk("rstw_stall_off", mem_stall, 1'b0);
    chk("rstw_req", bus_if.req, 1'b0);
    chk("rstw_rdata", mem_rdata, 32'd0);
    mem_en = 1'b1;
    #1;
    chk("rstw_stall_on", mem_stall, 1'b1);
    mem_en = 1'b0;
    step();
    chk("rstw_idle_req", bus_if.req, 1'b0);
    $display("seq reset_in_wait: req=%b stall=%b rdata=%h", bus_if.req, mem_stall, mem_rdata);

`ifdef DMEM_TIMEOUT_EN
    begin : timeout_seq
      int sc = 0;
      bit fin = 0;
      mem_en = 1'b1; mem_wstrb = '0; mem_addr = 32'h0000_0900;
      #1;
      for (int c = 0; c < 40 && !fin; c++) begin
        if (!mem_stall) fin = 1;
        else begin sc++; step(); end
      end
      chk("to_completes", 32'(fin), 32'd1);
      chk("to_stall_cycles", sc, 9);
      chk("to_err", mem_err, 1'b1);
      chk("to_rdata", mem_rdata, 32'd0);
      chk("to_req", bus_if.req, 1'b0);
      step();
      mem_en = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = 32'hFFFF_0000;
      #1;
      chk("to_err_pulse", mem_err, 1'b0);
      chk("to_idle_stall", mem_stall, 1'b0);
      step();
      bus_if.data_ok = 1'b0;
      chk("to_late_ignored", mem_rdata, 32'd0);
      $display("seq timeout: stall=%0d err_pulse_done", sc);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
